// File: rtl/complex_fir_pkg.sv
// Shared definitions for the complex-sample AXI-Stream blocks.
// Contents: the sample width, the I/Q field positions, the 2-entry buffer
// occupancy encoding, the buffered beat payload and an I/Q swap helper.
package complex_fir_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SCNT_W = 32;
  localparam int unsigned PCNT_W = 16;

  // I in the upper half, Q in the lower half
  localparam int unsigned I_MSB = 63;
  localparam int unsigned I_LSB = 32;
  localparam int unsigned Q_MSB = 31;
  localparam int unsigned Q_LSB = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Exchange the I and Q fields of a sample
  function automatic logic [DATA_W-1:0] swap_iq(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    r[I_MSB:I_LSB] = d[Q_MSB:Q_LSB];
    r[Q_MSB:Q_LSB] = d[I_MSB:I_LSB];
    return r;
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry AXI-Stream output buffer for one fanout branch.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, data_i      write one beat (never asserted while full)
//   ready_i             downstream ready
//   valid_o, data_o     registered head-of-buffer beat
//   full_next_c_o       occupancy after this edge will be TWO (combinational)
module axis_skid2
  import complex_fir_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  beat_t data_i,
  input  logic  ready_i,
  output logic  valid_o,
  output beat_t data_o,
  output logic  full_next_c_o
);

  occ_e  state_q, state_d;
  beat_t head_q, head_d;
  beat_t tail_q, tail_d;
  logic  valid_q, valid_d;
  logic  pop_c;

  assign pop_c = valid_q & ready_i;

  // State and storage registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  // Occupancy transitions; head always holds the oldest beat
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      OCC_EMPTY: begin
        if (push_i) begin
          head_d  = data_i;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push_i && pop_c) begin
          head_d = data_i;
        end else if (push_i) begin
          tail_d  = data_i;
          state_d = OCC_TWO;
        end else if (pop_c) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop_c) begin
          head_d  = tail_q;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    valid_d = (state_d != OCC_EMPTY);
  end

  assign valid_o       = valid_q;
  assign data_o        = head_q;
  assign full_next_c_o = (state_d == OCC_TWO);

endmodule

// File: rtl/complex_fanout_axis.sv
// Broadcasts a complex-sample AXI-Stream to two branches, each with its
// own 2-entry buffer, and counts accepted beats and packets.
// Build option: COMPLEX_FANOUT_SWAP_EN puts {Q,I} on branch 1.
// Ports:
//   S_AXIS_ACLK, S_AXIS_ARESETN   clock, asynchronous active-low reset
//   S_AXIS_*                      upstream sample stream (TSTRB ignored)
//   M0_AXIS_*, M1_AXIS_*          branch outputs, TSTRB all ones
//   sample_count, packet_count    accepted beats / accepted TLAST beats
module complex_fanout_axis
  import complex_fir_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = DATA_W
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              M0_AXIS_TVALID,
  input  logic                              M0_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   M0_AXIS_TDATA,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] M0_AXIS_TSTRB,
  output logic                              M0_AXIS_TLAST,
  output logic                              M1_AXIS_TVALID,
  input  logic                              M1_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   M1_AXIS_TDATA,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] M1_AXIS_TSTRB,
  output logic                              M1_AXIS_TLAST,
  output logic [SCNT_W-1:0]                 sample_count,
  output logic [PCNT_W-1:0]                 packet_count
);

  logic              tready_q;
  logic [SCNT_W-1:0] sample_cnt_q;
  logic [PCNT_W-1:0] pkt_cnt_q;
  logic              accept_c;
  beat_t             in0_c, in1_c, out0_c, out1_c;
  logic              full0_c, full1_c;
  logic              unused_strb;

  assign unused_strb = ^S_AXIS_TSTRB;
  assign accept_c    = S_AXIS_TVALID & tready_q;

  // Branch payloads; only branch 1 may carry swapped I/Q
  always_comb begin
    in0_c.last = S_AXIS_TLAST;
    in0_c.data = DATA_W'(S_AXIS_TDATA);
    in1_c.last = S_AXIS_TLAST;
`ifdef COMPLEX_FANOUT_SWAP_EN
    in1_c.data = swap_iq(DATA_W'(S_AXIS_TDATA));
`else
    in1_c.data = DATA_W'(S_AXIS_TDATA);
`endif
  end

  axis_skid2 u_skid0 (
    .clk_i         (S_AXIS_ACLK),
    .rst_ni        (S_AXIS_ARESETN),
    .push_i        (accept_c),
    .data_i        (in0_c),
    .ready_i       (M0_AXIS_TREADY),
    .valid_o       (M0_AXIS_TVALID),
    .data_o        (out0_c),
    .full_next_c_o (full0_c)
  );

  axis_skid2 u_skid1 (
    .clk_i         (S_AXIS_ACLK),
    .rst_ni        (S_AXIS_ARESETN),
    .push_i        (accept_c),
    .data_i        (in1_c),
    .ready_i       (M1_AXIS_TREADY),
    .valid_o       (M1_AXIS_TVALID),
    .data_o        (out1_c),
    .full_next_c_o (full1_c)
  );

  // Ready is registered from next occupancy, so it stays low until the
  // first edge after reset release and has no path from branch TREADY.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      tready_q <= 1'b0;
    end else begin
      tready_q <= ~(full0_c | full1_c);
    end
  end

  // Beat and packet counters, wrapping naturally
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      sample_cnt_q <= '0;
      pkt_cnt_q    <= '0;
    end else if (accept_c) begin
      sample_cnt_q <= sample_cnt_q + SCNT_W'(1);
      if (S_AXIS_TLAST) begin
        pkt_cnt_q <= pkt_cnt_q + PCNT_W'(1);
      end
    end
  end

  assign S_AXIS_TREADY = tready_q;
  assign M0_AXIS_TDATA = C_S_AXIS_TDATA_WIDTH'(out0_c.data);
  assign M0_AXIS_TLAST = out0_c.last;
  assign M0_AXIS_TSTRB = '1;
  assign M1_AXIS_TDATA = C_S_AXIS_TDATA_WIDTH'(out1_c.data);
  assign M1_AXIS_TLAST = out1_c.last;
  assign M1_AXIS_TSTRB = '1;
  assign sample_count  = sample_cnt_q;
  assign packet_count  = pkt_cnt_q;

endmodule

// File: tb/tb_complex_fanout_axis.sv
// Bench for complex_fanout_axis: scoreboard queues per branch, directed
// latency/backpressure/reset/swap cases and a random-ready soak.
module tb_complex_fanout_axis;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [63:0] s_data;
  logic [7:0]  s_strb;
  logic        m0_valid, m0_last, m1_valid, m1_last;
  logic        m0_ready = 1'b0;
  logic        m1_ready = 1'b0;
  logic [63:0] m0_data, m1_data;
  logic [7:0]  m0_strb, m1_strb;
  logic [31:0] sample_count;
  logic [15:0] packet_count;

  int total = 0;
  int bad   = 0;
  int mode  = 3;
  int m0_xfers = 0;
  int m1_xfers = 0;
  logic [15:0] pkt_model = '0;
  logic [64:0] exp0_q[$];
  logic [64:0] exp1_q[$];

  always #5 clk = ~clk;

  complex_fanout_axis dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .S_AXIS_TVALID  (s_valid),
    .S_AXIS_TREADY  (s_ready),
    .S_AXIS_TDATA   (s_data),
    .S_AXIS_TSTRB   (s_strb),
    .S_AXIS_TLAST   (s_last),
    .M0_AXIS_TVALID (m0_valid),
    .M0_AXIS_TREADY (m0_ready),
    .M0_AXIS_TDATA  (m0_data),
    .M0_AXIS_TSTRB  (m0_strb),
    .M0_AXIS_TLAST  (m0_last),
    .M1_AXIS_TVALID (m1_valid),
    .M1_AXIS_TREADY (m1_ready),
    .M1_AXIS_TDATA  (m1_data),
    .M1_AXIS_TSTRB  (m1_strb),
    .M1_AXIS_TLAST  (m1_last),
    .sample_count   (sample_count),
    .packet_count   (packet_count)
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_m1(input logic [63:0] d);
`ifdef COMPLEX_FANOUT_SWAP_EN
    return {d[31:0], d[63:32]};
`else
    return d;
`endif
  endfunction

  // Downstream ready patterns: 0 both, 1 only M0, 2 random, else none
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       begin m0_ready = 1'b1; m1_ready = 1'b1; end
      1:       begin m0_ready = 1'b1; m1_ready = 1'b0; end
      2:       begin m0_ready = 1'($urandom_range(0, 1)); m1_ready = 1'($urandom_range(0, 1)); end
      default: begin m0_ready = 1'b0; m1_ready = 1'b0; end
    endcase
  end

  // Branch monitors: a handshake seen at the negedge completes at the next posedge
  always @(negedge clk) begin
    if (rst_n && m0_valid && m0_ready) begin
      m0_xfers++;
      if (exp0_q.size() == 0) check("m0_unexpected", 65'(exp0_q.size()), 65'd1);
      else check("m0_beat", {m0_last, m0_data}, exp0_q.pop_front());
    end
    if (rst_n && m1_valid && m1_ready) begin
      m1_xfers++;
      if (exp1_q.size() == 0) check("m1_unexpected", 65'(exp1_q.size()), 65'd1);
      else check("m1_beat", {m1_last, m1_data}, exp1_q.pop_front());
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic l);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        exp0_q.push_back({l, d});
        exp1_q.push_back({l, exp_m1(d)});
        if (l) pkt_model = pkt_model + 16'd1;
        done = 1'b1;
      end else begin
        n++;
        if (n > 500) begin
          check("send_timeout", 65'(n), 65'd0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 65'(exp0_q.size() + exp1_q.size()), 65'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_m0_valid", 65'(m0_valid), 65'd0);
    check("rst_m1_valid", 65'(m1_valid), 65'd0);
    check("rst_tready", 65'(s_ready), 65'd0);
    check("rst_samples", 65'(sample_count), 65'd0);
    check("rst_packets", 65'(packet_count), 65'd0);
    check("rst_m0_data", {m0_last, m0_data}, 65'd0);
    exp0_q.delete();
    exp1_q.delete();
    pkt_model = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] held;
    int b0, b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_strb  = '1;
    rst_n   = 1'b0;
    #3;
    check("init_tready", 65'(s_ready), 65'd0);
    check("init_m0_valid", 65'(m0_valid), 65'd0);
    check("init_m1_valid", 65'(m1_valid), 65'd0);
    check("init_samples", 65'(sample_count), 65'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_before_edge", 65'(s_ready), 65'd0);
    @(posedge clk);
    #1;
    check("tready_after_edge", 65'(s_ready), 65'd1);

    // Two-beat packet, both branches ready
    mode = 0;
    @(posedge clk);
    #1;
    fork
      send_beat(64'h00010002_00030004, 1'b0);
      begin @(negedge clk); check("lat_not_early", 65'(m0_valid), 65'd0); end
    join
    fork
      send_beat(64'h00050006_00070008, 1'b1);
      begin
        @(negedge clk);
        check("lat_m0", {m0_valid, m0_data}, {1'b1, 64'h00010002_00030004});
        check("lat_m1", {m1_valid, m1_data}, {1'b1, exp_m1(64'h00010002_00030004)});
        check("m0_strb", 65'(m0_strb), 65'hFF);
        check("m1_strb", 65'(m1_strb), 65'hFF);
      end
    join
    drain();
    check("t1_samples", 65'(sample_count), 65'd2);
    check("t1_packets", 65'(packet_count), 65'd1);

    // Branch 1 stalled: acceptance stops at two beats
    b0 = m0_xfers;
    b1 = m1_xfers;
    mode = 1;
    @(posedge clk);
    #1;
    fork
      begin
        send_beat(64'h11111111_11111111, 1'b0);
        send_beat(64'h22222222_22222222, 1'b0);
        send_beat(64'h33333333_33333333, 1'b0);
        send_beat(64'h44444444_44444444, 1'b1);
      end
    join_none
    repeat (4) @(negedge clk);
    held = m1_data;
    repeat (8) @(negedge clk);
    check("stall_samples", 65'(sample_count), 65'd4);
    check("stall_tready", 65'(s_ready), 65'd0);
    check("stall_m0_xfers", 65'(m0_xfers - b0), 65'd2);
    check("stall_m1_head", {m1_valid, m1_data}, {1'b1, exp_m1(64'h11111111_11111111)});
    check("stall_m1_stable", 65'(m1_data), 65'(held));
    mode = 0;
    wait fork;
    drain();
    check("stall_done_samples", 65'(sample_count), 65'd6);
    check("stall_done_m0", 65'(m0_xfers - b0), 65'd4);
    check("stall_done_m1", 65'(m1_xfers - b1), 65'd4);

    // Random downstream readiness over 1000 beats
    apply_reset();
    mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat({$urandom, $urandom}, 1'($urandom_range(0, 7) == 0));
    end
    mode = 0;
    drain();
    check("rand_samples", 65'(sample_count), 65'd1000);
    check("rand_packets", 65'(packet_count), 65'(pkt_model));
    check("rand_tready", 65'(s_ready), 65'd1);

    // Reset with both branches full mid-packet
    mode = 3;
    @(posedge clk);
    #1;
    send_beat(64'hDEAD0001_BEEF0001, 1'b0);
    send_beat(64'hDEAD0002_BEEF0002, 1'b0);
    repeat (2) @(negedge clk);
    check("full_tready", 65'(s_ready), 65'd0);
    check("full_valids", 65'({m0_valid, m1_valid}), 65'd3);
    apply_reset();
    mode = 0;
    send_beat(64'h0A0A0A0A_0B0B0B0B, 1'b0);
    send_beat(64'h0C0C0C0C_0D0D0D0D, 1'b0);
    send_beat(64'h0E0E0E0E_0F0F0F0F, 1'b1);
    drain();
    check("post_rst_samples", 65'(sample_count), 65'd3);
    check("post_rst_packets", 65'(packet_count), 65'd1);

    // I/Q placement per branch
    mode = 3;
    @(posedge clk);
    #1;
    send_beat(64'hAAAA0000_0000BBBB, 1'b0);
    @(negedge clk);
    check("swap_m0", 65'(m0_data), 65'h0_AAAA0000_0000BBBB);
`ifdef COMPLEX_FANOUT_SWAP_EN
    check("swap_m1", 65'(m1_data), 65'h0_0000BBBB_AAAA0000);
`else
    check("swap_m1", 65'(m1_data), 65'h0_AAAA0000_0000BBBB);
`endif
    mode = 0;
    drain();

    // Sample counter wrap
    force dut.sample_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    check("wrap_preload", 65'(sample_count), 65'hFFFF_FFFF);
    @(posedge clk);
    #1;
    release dut.sample_cnt_q;
    send_beat(64'h12345678_9ABCDEF0, 1'b0);
    drain();
    check("wrap_samples", 65'(sample_count), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    check("watchdog", 65'd1, 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/complex_fanout_axis.md
COMPLEX_FANOUT_AXIS -- requirements
Module: complex_fanout_axis

Interface
REQ-001 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 64, the complex sample width: I in [63:32], Q in [31:0].
REQ-002 SHALL have port S_AXIS_ACLK, input, 1 bit: the single clock; one clock, every register is clocked on its rising edge.
REQ-003 SHALL have port S_AXIS_ARESETN, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have S_AXIS_TVALID (in, 1), S_AXIS_TREADY (out, 1), S_AXIS_TDATA (in, 64), S_AXIS_TSTRB (in, 8, ignored) and S_AXIS_TLAST (in, 1) as the upstream complex sample stream.
REQ-005 SHALL have M0_AXIS_TVALID (out, 1), M0_AXIS_TREADY (in, 1), M0_AXIS_TDATA (out, 64), M0_AXIS_TSTRB (out, 8) and M0_AXIS_TLAST (out, 1) as branch 0, feeding the combiner's S0 input.
REQ-006 SHALL have the same five signals prefixed M1_AXIS_ as branch 1, feeding the combiner's S1 input.
REQ-007 SHALL have sample_count (out, 32), the number of accepted beats, and packet_count (out, 16), the number of accepted TLAST beats.

Function
REQ-008 SHALL broadcast every accepted input beat to both branches exactly once, in order, with TDATA and TLAST unmodified except as stated in REQ-020.
REQ-009 SHALL accept an input beat when S_AXIS_TVALID and S_AXIS_TREADY are both 1 on a rising edge.
REQ-010 SHALL drive S_AXIS_TREADY = 1 only when both branch buffers have occupancy below 2 and reset is deasserted; it is derived from registered occupancy only, with no combinational path from any M*_AXIS_TREADY.
REQ-011 SHALL give each branch its own 2-entry buffer with occupancy states EMPTY, ONE and TWO.
- Push only: EMPTY->ONE, ONE->TWO.
- Pop only: TWO->ONE, ONE->EMPTY.
- Push and pop in the same cycle in ONE: stay in ONE.
- Push in TWO is impossible by REQ-010.
REQ-012 SHALL drive M*_AXIS_TVALID = 1 exactly when that branch is not EMPTY; the head entry drives TDATA and TLAST.
REQ-013 SHALL pop a branch when its TVALID and TREADY are both 1, independently of the other branch.
REQ-014 SHALL have a latency of one cycle: a beat accepted at edge N is presented on an empty branch after edge N and transfers at edge N+1 at the earliest.
REQ-015 SHALL allow the branches to drift apart by at most 2 beats; a stalled branch stops input acceptance once it reaches TWO, while the other branch drains.
REQ-016 SHALL hold TDATA, TLAST and TVALID stable on a branch while TVALID=1 and TREADY=0.
REQ-017 SHALL drive M*_AXIS_TSTRB to all ones.
REQ-018 SHALL increment sample_count on each accepted beat, wrapping from 0xFFFFFFFF to 0; packet_count likewise on each accepted beat with TLAST=1, wrapping at 0xFFFF.

Reset
REQ-019 SHALL, while S_AXIS_ARESETN=0, force the following immediately and asynchronously:
- both branches EMPTY;
- all TVALID and S_AXIS_TREADY to 0;
- buffer data, TLAST, sample_count and packet_count to 0.
Reset asserted mid-packet discards all buffered beats, and the first beat after release starts a new packet. S_AXIS_TREADY rises on the first edge after release.

Configuration
REQ-020 SHALL, with macro COMPLEX_FANOUT_SWAP_EN defined, place {Q,I} on branch 1 (M1_AXIS_TDATA[63:32]=Q, [31:0]=I); branch 0 is always unswapped. Without the macro, both branches carry {I,Q}.

Structure
REQ-021 SHALL take the data width, the I/Q field bit positions and the occupancy state encoding from the shared package complex_fir_pkg.
REQ-022 SHALL implement the 2-entry buffer as sub-module axis_skid2, instantiated once per branch.

Verification
REQ-023 Bench SHALL drive both branches TREADY=1 and input beats 0x00010002_00030004 then 0x00050006_00070008 (TLAST) on consecutive cycles; required: both branches emit the same two beats, each one cycle after acceptance, with TLAST on the second, packet_count=1 and sample_count=2.
REQ-024 Bench SHALL hold M1 TREADY=0 with M0 TREADY=1 and send 4 beats; required: M0 emits 2 beats, S_AXIS_TREADY drops after 2 accepts, M1 holds beat 1 stable; on releasing M1 all 4 beats reach both branches in order.
REQ-025 Bench SHALL toggle both TREADY signals randomly over 1000 beats; required: no loss, no duplication or reordering per branch, and sample_count=1000.
REQ-026 Bench SHALL assert reset with both branches in TWO mid-packet; required: TVALID=0 immediately, counters=0, and the next packet is delivered intact.
REQ-027 Bench SHALL build with COMPLEX_FANOUT_SWAP_EN and input 0xAAAA0000_0000BBBB; required: M1 shows 0x0000BBBB_AAAA0000 and M0 is unchanged. The same bench SHALL preload sample_count to 0xFFFFFFFF via force and accept 1 beat; required: sample_count=0.
